// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage and its queues.
package rv_fetch_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [31:0]         instr;
   } fetch_entry_t;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a registered head, push/pop at any occupancy.
module fetch_fifo
   import rv_fetch_pkg::*;
#(
   parameter int unsigned  DEPTH = 2,
   localparam int unsigned PtrW  = ptr_width(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear_i,
   input  logic         push_i,
   input  fetch_entry_t entry_i,
   input  logic         pop_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [PtrW:0] count_o,
   output fetch_entry_t head_o
);

   fetch_entry_t    mem_q [DEPTH];
   fetch_entry_t    head_q, head_d;
   logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [PtrW:0]   cnt_q, cnt_d, remain;
   logic            do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (PtrW+1)'(DEPTH));
   assign count_o = cnt_q;
   assign head_o  = head_q;

   always_comb begin
      do_pop  = pop_i && !empty_o && !clear_i;
      do_push = push_i && (!full_o || do_pop) && !clear_i;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      head_d  = head_q;
      remain  = cnt_q - {{PtrW{1'b0}}, do_pop};
      if (clear_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + 1'b1;
         if (do_pop)  rd_d = rd_q + 1'b1;
         cnt_d = remain + {{PtrW{1'b0}}, do_push};
         // Head tracks the oldest entry; when it drains, it keeps the last one shown.
         if (cnt_d != '0) head_d = (remain == '0) ? entry_i : mem_q[rd_d];
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= entry_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         head_q <= '{pc: '0, instr: NOP_INSTR};
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         head_q <= head_d;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word fetches, buffers results for IF/ID.
module if_fetch_stage
   import rv_fetch_pkg::*;
#(
   parameter int unsigned      XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0]  RESET_PC = '0,
   parameter int unsigned      DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [31:0]     if_instr
);

   localparam int unsigned PtrW = ptr_width(DEPTH);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [PtrW:0]   out_q, out_d, drop_q, drop_d;
   logic [PtrW:0]   fifo_count, infl_count, rsp_dec, acc_inc;
   logic [PtrW+1:0] credit_used;
   logic            fifo_empty, fifo_full, infl_empty, infl_full;
   logic            accept, rsp_keep, fifo_pop;
   fetch_entry_t    fifo_head, infl_head, req_entry, rsp_entry;
   logic            unused_bits;

   // Outstanding plus buffered never exceeds DEPTH, so the output FIFO cannot overflow.
   assign credit_used    = {1'b0, out_q} + {1'b0, fifo_count};
   assign imem_req_valid = !rst && !redirect_valid && (credit_used < (PtrW+2)'(DEPTH));
   assign imem_req_addr  = pc_q;
   assign accept         = imem_req_valid && imem_req_ready;
   assign rsp_keep       = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
   assign fifo_pop       = !fifo_empty && if_ready && !redirect_valid;
   assign rsp_dec        = {{PtrW{1'b0}}, imem_rsp_valid};
   assign acc_inc        = {{PtrW{1'b0}}, accept};

   assign req_entry = '{pc: pc_q, instr: NOP_INSTR};
   assign rsp_entry = '{pc: infl_head.pc, instr: imem_rsp_data};

   assign if_valid = !fifo_empty;
   assign if_pc    = fifo_head.pc;
   assign if_instr = fifo_empty ? NOP_INSTR : fifo_head.instr;

   always_comb begin
      pc_d   = pc_q;
      out_d  = out_q;
      drop_d = drop_q;
      if (redirect_valid) begin
         // Everything still in flight belongs to the wrong path; a response this cycle is gone too.
         pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
         out_d  = out_q - rsp_dec;
         drop_d = out_q - rsp_dec;
      end else begin
         if (accept) pc_d = pc_q + XLEN'(4);
         out_d = out_q + acc_inc - rsp_dec;
         if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         out_q  <= '0;
         drop_q <= '0;
      end else begin
         pc_q   <= pc_d;
         out_q  <= out_d;
         drop_q <= drop_d;
      end
   end

   fetch_fifo #(
      .DEPTH(DEPTH)
   ) u_infl_q (
      .clk    (clk),
      .rst    (rst),
      .clear_i(redirect_valid),
      .push_i (accept),
      .entry_i(req_entry),
      .pop_i  (rsp_keep),
      .full_o (infl_full),
      .empty_o(infl_empty),
      .count_o(infl_count),
      .head_o (infl_head)
   );

   fetch_fifo #(
      .DEPTH(DEPTH)
   ) u_out_q (
      .clk    (clk),
      .rst    (rst),
      .clear_i(redirect_valid),
      .push_i (rsp_keep),
      .entry_i(rsp_entry),
      .pop_i  (fifo_pop),
      .full_o (fifo_full),
      .empty_o(fifo_empty),
      .count_o(fifo_count),
      .head_o (fifo_head)
   );

   assign unused_bits = ^{infl_head.instr, infl_full, infl_empty, infl_count, fifo_full,
                          redirect_pc[1:0]};

endmodule
